// File: rtl/heap_pkg.sv
// Shared types and constants for the pipelined heap: op encoding, issue FSM states
// and the op record handed from the issue front-end to the heap stages.
package heap_pkg;

  localparam int HEAP_CNT_W  = 20;
  localparam int HEAP_ADDR_W = 28;
  localparam int HEAP_LEVELS = 6;

  localparam logic OP_INSERT = 1'b0;
  localparam logic OP_QUERY  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } issue_state_t;

  typedef struct packed {
    logic                   opcode;
    logic [HEAP_CNT_W-1:0]  cnt;
    logic [HEAP_ADDR_W-1:0] addr;
    logic [HEAP_LEVELS-1:0] path;
    logic [HEAP_LEVELS-1:0] elem_cnt;
  } heap_op_t;

  // An insert targets the next free slot (1-based); a query just reports the count.
  function automatic heap_op_t make_op(input logic opcode,
                                       input logic [HEAP_CNT_W-1:0] cnt,
                                       input logic [HEAP_ADDR_W-1:0] addr,
                                       input logic [HEAP_LEVELS-1:0] count);
    heap_op_t op;
    op.opcode   = opcode;
    op.cnt      = cnt;
    op.addr     = addr;
    op.path     = (opcode == OP_INSERT) ? count + HEAP_LEVELS'(1) : count;
    op.elem_cnt = count;
    return op;
  endfunction

endpackage

// File: rtl/heap_req_reg.sv
// Single-entry op register: captures an accepted request on load, holds otherwise.
module heap_req_reg
  import heap_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     load,
  input  heap_op_t d,
  output heap_op_t q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/heap_issue_ctrl.sv
// Issue front-end for heap level 1: accepts insert/query requests, tracks the element
// count and issues one op every two cycles. Define HEAP_ISSUE_DROP_CNT_EN for drop_cnt_o.
module heap_issue_ctrl
  import heap_pkg::*;
#(
  parameter int CNT_SIZE    = HEAP_CNT_W,
  parameter int ADDR_SIZE   = HEAP_ADDR_W,
  parameter int TOTAL_LEVEL = HEAP_LEVELS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_opcode_i,
  input  logic [CNT_SIZE-1:0]    req_cnt_i,
  input  logic [ADDR_SIZE-1:0]   req_addr_i,
  input  logic [CNT_SIZE-1:0]    root_cnt_i,
  input  logic [ADDR_SIZE-1:0]   root_addr_i,
  output logic                   valid_o,
  output logic                   opcode_o,
  output logic [CNT_SIZE-1:0]    wcnt_o,
  output logic [ADDR_SIZE-1:0]   waddr_o,
  output logic [TOTAL_LEVEL-1:0] insert_path_o,
  output logic [TOTAL_LEVEL-1:0] index_o,
  output logic [TOTAL_LEVEL-1:0] heap_element_cnt_o,
  output logic                   rsp_valid_o,
  output logic [CNT_SIZE-1:0]    rsp_cnt_o,
  output logic [ADDR_SIZE-1:0]   rsp_addr_o,
  output logic                   rsp_empty_o,
  output logic                   full_o,
`ifdef HEAP_ISSUE_DROP_CNT_EN
  output logic [15:0]            drop_cnt_o,
`endif
  output logic [TOTAL_LEVEL-1:0] count_o
);

  localparam logic [TOTAL_LEVEL-1:0] CAP = '1;
  localparam logic [TOTAL_LEVEL-1:0] ONE = TOTAL_LEVEL'(1);

  // Handshake: a request transfers on a cycle where req_valid_i and req_ready_o are
  // both high; the requester holds valid and data stable while ready is low.
  issue_state_t           state;
  logic                   ready_q;
  logic                   valid_q;
  logic [TOTAL_LEVEL-1:0] count;
  logic                   accept;
  logic                   is_full;
  logic                   drop;
  logic                   load;
  heap_op_t               op_d;
  heap_op_t               op_q;

  assign accept  = req_valid_i & ready_q;
  assign is_full = (count == CAP);
  assign drop    = accept & (req_opcode_i == OP_INSERT) & is_full;
  assign load    = accept & ~drop;

  always_comb begin
    op_d = make_op(req_opcode_i, req_cnt_i, req_addr_i, count);
  end

  heap_req_reg u_req_reg (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .d    (op_d),
    .q    (op_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      count   <= '0;
    end else begin
      case (state)
        IDLE, GAP: begin
          if (load) begin
            state   <= ISSUE;
            ready_q <= 1'b0;
            valid_q <= 1'b1;
          end else if (drop) begin
            state   <= GAP;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
          end else begin
            state   <= IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        ISSUE: begin
          state   <= GAP;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
          if (op_q.opcode == OP_INSERT) begin
            count <= count + ONE;
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef HEAP_ISSUE_DROP_CNT_EN
  logic [15:0] drop_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign drop_cnt_o = drop_cnt;
`endif

  // Stage 1 must never see a query opcode without valid.
  assign req_ready_o        = ready_q;
  assign valid_o            = valid_q;
  assign opcode_o           = valid_q & op_q.opcode;
  assign wcnt_o             = op_q.cnt;
  assign waddr_o            = op_q.addr;
  assign insert_path_o      = op_q.path;
  assign heap_element_cnt_o = op_q.elem_cnt;
  assign index_o            = '0;

  assign rsp_valid_o = valid_q & (op_q.opcode == OP_QUERY);
  assign rsp_empty_o = rsp_valid_o & (count == '0);
  assign rsp_cnt_o   = (rsp_valid_o && count != '0) ? root_cnt_i  : '0;
  assign rsp_addr_o  = (rsp_valid_o && count != '0) ? root_addr_i : '0;

  assign full_o  = is_full;
  assign count_o = count;

endmodule

// File: tb/tb_heap_issue_ctrl.sv
// Directed bench for heap_issue_ctrl: insert cadence, queries, full-drop and reset abort.
module tb_heap_issue_ctrl;

  localparam int CW = 20;
  localparam int AW = 28;
  localparam int L  = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_opcode;
  logic [CW-1:0] req_cnt;
  logic [AW-1:0] req_addr;
  logic [CW-1:0] root_cnt;
  logic [AW-1:0] root_addr;
  logic          valid;
  logic          opcode;
  logic [CW-1:0] wcnt;
  logic [AW-1:0] waddr;
  logic [L-1:0]  insert_path;
  logic [L-1:0]  index;
  logic [L-1:0]  heap_element_cnt;
  logic          rsp_valid;
  logic [CW-1:0] rsp_cnt;
  logic [AW-1:0] rsp_addr;
  logic          rsp_empty;
  logic          full;
  logic [L-1:0]  count;
`ifdef HEAP_ISSUE_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  heap_issue_ctrl dut (
    .clk                (clk),
    .rst                (rst),
    .req_valid_i        (req_valid),
    .req_ready_o        (req_ready),
    .req_opcode_i       (req_opcode),
    .req_cnt_i          (req_cnt),
    .req_addr_i         (req_addr),
    .root_cnt_i         (root_cnt),
    .root_addr_i        (root_addr),
    .valid_o            (valid),
    .opcode_o           (opcode),
    .wcnt_o             (wcnt),
    .waddr_o            (waddr),
    .insert_path_o      (insert_path),
    .index_o            (index),
    .heap_element_cnt_o (heap_element_cnt),
    .rsp_valid_o        (rsp_valid),
    .rsp_cnt_o          (rsp_cnt),
    .rsp_addr_o         (rsp_addr),
    .rsp_empty_o        (rsp_empty),
    .full_o             (full),
`ifdef HEAP_ISSUE_DROP_CNT_EN
    .drop_cnt_o         (drop_cnt),
`endif
    .count_o            (count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one request at a negedge and wait (bounded) until it is accepted; returns
  // at the negedge of the cycle after acceptance.
  task automatic do_req(input logic op, input logic [CW-1:0] c, input logic [AW-1:0] a);
    int   n;
    logic acc;
    n          = 0;
    acc        = 1'b0;
    req_valid  = 1'b1;
    req_opcode = op;
    req_cnt    = c;
    req_addr   = a;
    while (!acc && n < 20) begin
      acc = req_ready;
      @(negedge clk);
      n++;
    end
    if (!acc) check("accept_timeout", 32'(acc), 32'd1);
    req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_opcode = 1'b0; req_cnt = '0; req_addr = '0;
    root_cnt = '0; root_addr = '0;
    repeat (2) @(negedge clk);

    // reset state
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_opcode", 32'(opcode), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_path", 32'(insert_path), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
`ifdef HEAP_ISSUE_DROP_CNT_EN
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    rst = 1'b0;

    // first insert: accepted at N, issued at N+1
    do_req(1'b0, 20'd5, 28'h10);
    check("t1_valid", 32'(valid), 32'd1);
    check("t1_opcode", 32'(opcode), 32'd0);
    check("t1_path", 32'(insert_path), 32'd1);
    check("t1_elem", 32'(heap_element_cnt), 32'd0);
    check("t1_index", 32'(index), 32'd0);
    check("t1_wcnt", 32'(wcnt), 32'd5);
    check("t1_waddr", 32'(waddr), 32'h10);
    check("t1_ready_issue", 32'(req_ready), 32'd0);
    check("t1_count_issue", 32'(count), 32'd0);
    @(negedge clk);
    check("t1_valid_gap", 32'(valid), 32'd0);
    check("t1_count_after", 32'(count), 32'd1);
    check("t1_ready_gap", 32'(req_ready), 32'd1);

    // back-to-back inserts with valid held: issue on alternate cycles only
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i + 2));
    req_valid = 1'b1; req_opcode = 1'b0; req_cnt = 20'd100; req_addr = 28'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t2_valid_issue", 32'(valid), 32'd1);
      check("t2_ready_issue", 32'(req_ready), 32'd0);
      check("t2_path", 32'(insert_path), exp_q.pop_front());
      check("t2_wcnt", 32'(wcnt), 32'(100 + i));
      if (i < 3) begin
        req_cnt  = 20'(101 + i);
        req_addr = 28'(i + 1);
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
      check("t2_valid_gap", 32'(valid), 32'd0);
      check("t2_opcode_gap", 32'(opcode), 32'd0);
      check("t2_ready_gap", 32'(req_ready), 32'd1);
    end
    check("t2_count", 32'(count), 32'd5);
    @(negedge clk);

    // reset during ISSUE discards the op
    do_req(1'b0, 20'd7, 28'h7);
    check("t6_valid_issue", 32'(valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_valid", 32'(valid), 32'd0);
    check("t6_count", 32'(count), 32'd0);
    check("t6_ready", 32'(req_ready), 32'd1);
    rst = 1'b0;

    // query on empty heap: root inputs must be masked
    root_cnt = 20'h55; root_addr = 28'h33;
    do_req(1'b1, 20'd0, 28'd0);
    check("t3_valid", 32'(valid), 32'd1);
    check("t3_opcode", 32'(opcode), 32'd1);
    check("t3_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t3_rsp_empty", 32'(rsp_empty), 32'd1);
    check("t3_rsp_cnt", 32'(rsp_cnt), 32'd0);
    check("t3_rsp_addr", 32'(rsp_addr), 32'd0);
    @(negedge clk);
    check("t3_count", 32'(count), 32'd0);
    check("t3_rsp_valid_gap", 32'(rsp_valid), 32'd0);

    // query with three elements
    for (int i = 0; i < 3; i++) do_req(1'b0, 20'(10 + i), 28'(i));
    @(negedge clk);
    check("t5_count_pre", 32'(count), 32'd3);
    check("t5_full_pre", 32'(full), 32'd0);
    root_cnt = 20'd42; root_addr = 28'h7;
    do_req(1'b1, 20'd0, 28'd0);
    check("t5_valid", 32'(valid), 32'd1);
    check("t5_opcode", 32'(opcode), 32'd1);
    check("t5_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t5_rsp_cnt", 32'(rsp_cnt), 32'd42);
    check("t5_rsp_addr", 32'(rsp_addr), 32'h7);
    check("t5_rsp_empty", 32'(rsp_empty), 32'd0);
    check("t5_path", 32'(insert_path), 32'd3);
    check("t5_elem", 32'(heap_element_cnt), 32'd3);
    @(negedge clk);
    check("t5_opcode_gap", 32'(opcode), 32'd0);
    check("t5_count", 32'(count), 32'd3);

    // fill to capacity, then a dropped insert
    for (int i = 0; i < 60; i++) begin
      do_req(1'b0, 20'(200 + i), 28'(i));
      if (i == 59) begin
        check("t4_last_path", 32'(insert_path), 32'd63);
        check("t4_full_at_62", 32'(full), 32'd0);
      end
    end
    @(negedge clk);
    check("t4_count_full", 32'(count), 32'd63);
    check("t4_full", 32'(full), 32'd1);
    do_req(1'b0, 20'd99, 28'h99);
    check("t4_drop_valid", 32'(valid), 32'd0);
    check("t4_drop_count", 32'(count), 32'd63);
    check("t4_drop_full", 32'(full), 32'd1);
    check("t4_drop_ready", 32'(req_ready), 32'd1);
`ifdef HEAP_ISSUE_DROP_CNT_EN
    check("t4_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
    @(negedge clk);
    check("t4_drop_valid_next", 32'(valid), 32'd0);
    check("t4_drop_count_next", 32'(count), 32'd63);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/heap_issue_ctrl.md
Name: heap_issue_ctrl

Overview:
- Front-end feeding level 1 of the pipelined heap (the first heap_stage instance).
- Accepts insert/query requests over a valid/ready handshake and tracks the heap element count.
- For each insert, computes the insert path and pre-insert count, and issues ops at the two-cycle cadence the stages require.
- Answers root queries from the level-1 storage outputs.

Parameters:
- CNT_SIZE, 20, width of counter/priority value.
- ADDR_SIZE, 28, width of address tag.
- TOTAL_LEVEL, 6, heap depth; capacity CAP = 2**TOTAL_LEVEL - 1 (63).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid & ready.
- req_opcode_i  in  1  0 = insert, 1 = query root.
- req_cnt_i  in  CNT_SIZE  insert value.
- req_addr_i  in  ADDR_SIZE  insert address.
- root_cnt_i  in  CNT_SIZE  level-1 stored value.
- root_addr_i  in  ADDR_SIZE  level-1 stored address.
- valid_o  out  1  op valid to stage 1.
- opcode_o  out  1  op to stage 1.
- wcnt_o  out  CNT_SIZE  op value.
- waddr_o  out  ADDR_SIZE  op address.
- insert_path_o  out  TOTAL_LEVEL  1-based position of the new node (count+1).
- index_o  out  TOTAL_LEVEL  always 0 (root index).
- heap_element_cnt_o  out  TOTAL_LEVEL  count before this insert.
- rsp_valid_o  out  1  query response pulse.
- rsp_cnt_o  out  CNT_SIZE  root value.
- rsp_addr_o  out  ADDR_SIZE  root address.
- rsp_empty_o  out  1  heap was empty at query.
- full_o  out  1  count == CAP.
- count_o  out  TOTAL_LEVEL  current element count.

Behaviour:
- Reset: every output 0 except req_ready_o = 1; count = 0; FSM = IDLE.
- FSM states:
  - IDLE: ready = 1. On accept, register the op and go to ISSUE.
  - ISSUE: outputs driven for exactly one cycle with valid_o = 1. Go to GAP.
  - GAP: valid_o = 0, opcode_o = 0, ready = 1. Accept → ISSUE, else → IDLE.
- Latency and throughput: accept at cycle N → valid_o at N+1. Max one op per 2 cycles.
- Outside ISSUE, opcode_o is forced to 0 and valid_o to 0. Stage 1 must never see opcode 1 without valid.
- Insert at accept:
  - If count < CAP: latch heap_element_cnt_o = count and insert_path_o = count+1; count increments in the ISSUE cycle.
  - If count == CAP: the request is accepted and dropped. No ISSUE, valid_o stays 0, FSM goes to GAP, count is unchanged.
- Query:
  - Issued as valid_o = 1, opcode_o = 1, path/count fields = current count.
  - rsp_valid_o pulses in the ISSUE cycle: rsp_cnt_o/rsp_addr_o = root_cnt_i/root_addr_i, rsp_empty_o = (count == 0).
  - If count == 0, rsp_cnt_o and rsp_addr_o are 0.
  - Query does not alter count.
- Arithmetic: count+1 is computed in TOTAL_LEVEL bits. It cannot overflow because insert is blocked at CAP.
- Full/empty flags are combinational from count. full_o asserts the cycle after the CAP-th insert issues.
- req_valid_i while ready = 0 is held by the requester; data must stay stable (standard valid/ready).
- Reset mid-operation: the in-flight registered op is discarded, valid_o drops the next cycle, count returns to 0.

Optional Feature:
- Macro: HEAP_ISSUE_DROP_CNT_EN.
- When defined: adds output drop_cnt_o [15:0], counting inserts dropped while full. It saturates at 16'hFFFF and resets to 0.
- When undefined: the port is absent and drops are silent.

Decomposition:
- Shared package heap_pkg holds:
  - opcode constants OP_INSERT = 1'b0, OP_QUERY = 1'b1.
  - issue FSM state enum (IDLE, ISSUE, GAP).
  - typedef heap_op_t struct {opcode, cnt, addr, path, elem_cnt}, shared with the stages.
- One natural sub-module: heap_req_reg, the single-entry op register with load/hold, instantiated once.

Test Plan:
- After reset, insert cnt = 5, addr = 0x10 → next cycle valid_o = 1, insert_path_o = 1, heap_element_cnt_o = 0, index_o = 0; count_o = 1 the cycle after.
- Req_valid held high with 4 inserts → valid_o pulses on alternate cycles only; insert_path_o = 2, 3, 4, 5; req_ready_o low in ISSUE cycles.
- Query on empty heap → rsp_valid_o = 1, rsp_empty_o = 1, rsp_cnt_o = 0; count_o stays 0.
- Fill 63 inserts, then insert cnt = 99 → full_o = 1, no valid_o, count_o = 63; with HEAP_ISSUE_DROP_CNT_EN defined, drop_cnt_o = 1.
- Query with root_cnt_i = 42, root_addr_i = 0x7, count = 3 → rsp_cnt_o = 42, rsp_addr_o = 0x7, rsp_empty_o = 0, opcode_o = 1 for one cycle.
- Assert rst during ISSUE → next cycle valid_o = 0, count_o = 0, req_ready_o = 1.
